// File: rtl/pipe_stagereg.sv
// rtl/pipe_stagereg.sv - DEPTH-stage valid/payload pipeline register with stall, flush and occupancy.
// Optional bubble counter output bubble_cnt is built only when PIPE_STAGEREG_PERFCNT_EN is defined.
module pipe_stagereg #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              stall,
  input  logic              flush,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        occupancy
`ifdef PIPE_STAGEREG_PERFCNT_EN
  ,
  output logic [31:0]       bubble_cnt
`endif
);

  logic [DEPTH-1:0]  r_valid;
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [3:0]        w_occ;

  // Valid bits obey flush; payloads only obey stall, so bubbles keep carrying data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_data[k] <= '0;
      end
    end else begin
      if (flush) begin
        r_valid <= '0;
      end else if (!stall) begin
        r_valid[0] <= in_valid;
        for (int k = 1; k < DEPTH; k++) begin
          r_valid[k] <= r_valid[k-1];
        end
      end
      if (!stall) begin
        r_data[0] <= in_data;
        for (int k = 1; k < DEPTH; k++) begin
          r_data[k] <= r_data[k-1];
        end
      end
    end
  end

  always_comb begin
    w_occ = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_occ = w_occ + 4'(r_valid[k]);
    end
  end

  assign in_ready  = ~stall;
  assign out_valid = r_valid[DEPTH-1];
  assign out_data  = r_data[DEPTH-1];
  assign occupancy = w_occ;

`ifdef PIPE_STAGEREG_PERFCNT_EN
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bubble_cnt <= '0;
    end else if (!stall && !r_valid[DEPTH-1] && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_stagereg.sv
// tb/tb_pipe_stagereg.sv - scoreboard bench for pipe_stagereg across several DEPTH/DATA_W builds.
module tb_pipe_stagereg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic a_vld, a_stall, a_flush, a_rdy, a_ov;
  logic [31:0] a_dat, a_od;
  logic [3:0]  a_occ;

  logic b_vld, b_stall, b_flush, b_rdy, b_ov;
  logic [7:0] b_dat, b_od;
  logic [3:0] b_occ;

  logic cd_vld, cd_stall, cd_flush, c_rdy, c_ov, d_rdy, d_ov;
  logic [127:0] cd_dat, c_od;
  logic d_od;
  logic [3:0] c_occ, d_occ;

  logic e_vld, e_stall, e_flush, e_rdy, e_ov;
  logic [15:0] e_dat, e_od;
  logic [3:0]  e_occ;
`ifdef PIPE_STAGEREG_PERFCNT_EN
  logic [31:0] e_bub;
`endif

  pipe_stagereg #(.DATA_W(32), .DEPTH(3)) dut_a (
    .clk(clk), .reset(rst_n), .in_valid(a_vld), .in_data(a_dat), .stall(a_stall), .flush(a_flush),
    .in_ready(a_rdy), .out_valid(a_ov), .out_data(a_od), .occupancy(a_occ)
`ifdef PIPE_STAGEREG_PERFCNT_EN
    , .bubble_cnt()
`endif
  );
  pipe_stagereg #(.DATA_W(8), .DEPTH(2)) dut_b (
    .clk(clk), .reset(rst_n), .in_valid(b_vld), .in_data(b_dat), .stall(b_stall), .flush(b_flush),
    .in_ready(b_rdy), .out_valid(b_ov), .out_data(b_od), .occupancy(b_occ)
`ifdef PIPE_STAGEREG_PERFCNT_EN
    , .bubble_cnt()
`endif
  );
  pipe_stagereg #(.DATA_W(128), .DEPTH(8)) dut_c (
    .clk(clk), .reset(rst_n), .in_valid(cd_vld), .in_data(cd_dat), .stall(cd_stall), .flush(cd_flush),
    .in_ready(c_rdy), .out_valid(c_ov), .out_data(c_od), .occupancy(c_occ)
`ifdef PIPE_STAGEREG_PERFCNT_EN
    , .bubble_cnt()
`endif
  );
  pipe_stagereg #(.DATA_W(1), .DEPTH(8)) dut_d (
    .clk(clk), .reset(rst_n), .in_valid(cd_vld), .in_data(cd_dat[0]), .stall(cd_stall), .flush(cd_flush),
    .in_ready(d_rdy), .out_valid(d_ov), .out_data(d_od), .occupancy(d_occ)
`ifdef PIPE_STAGEREG_PERFCNT_EN
    , .bubble_cnt()
`endif
  );
  pipe_stagereg #(.DATA_W(16), .DEPTH(1)) dut_e (
    .clk(clk), .reset(rst_n), .in_valid(e_vld), .in_data(e_dat), .stall(e_stall), .flush(e_flush),
    .in_ready(e_rdy), .out_valid(e_ov), .out_data(e_od), .occupancy(e_occ)
`ifdef PIPE_STAGEREG_PERFCNT_EN
    , .bubble_cnt(e_bub)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int           id;
    logic [127:0] d;
    int           age;
  } item_t;
  item_t sb[$];
  logic [31:0] exp_bub;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // age counts unstalled edges since acceptance; an item sits at the output when age == depth
  task automatic upd(input int id, input int depth, input bit adv, input bit fl, input bit acc,
                     input logic [127:0] d);
    if (fl) begin
      for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].id == id) sb.delete(i);
    end else if (adv) begin
      for (int i = 0; i < sb.size(); i++) if (sb[i].id == id) sb[i].age++;
      for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].id == id && sb[i].age > depth) sb.delete(i);
      if (acc) sb.push_back('{id: id, d: d, age: 1});
    end
  endtask

  task automatic chk_inst(input int id, input int depth, input string nm, input logic ov,
                          input logic [127:0] od, input logic [3:0] occ);
    int n;
    int f;
    bit exp_ov;
    n = 0;
    f = -1;
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].id == id) begin
        n++;
        if (f < 0) f = i;
      end
    end
    exp_ov = (f >= 0) && (sb[f].age == depth);
    chk({nm, ".out_valid"}, 128'(ov), 128'(exp_ov));
    if (exp_ov) chk({nm, ".out_data"}, od, sb[f].d);
    chk({nm, ".occupancy"}, 128'(occ), 128'(n));
  endtask

  task automatic tick();
    bit a_acc, b_acc, cd_acc, e_acc, a_adv, b_adv, cd_adv, e_adv, a_fl, b_fl, cd_fl, e_fl, live, bub;
    logic [127:0] a_d, b_d, c_d, d_d, e_d;
    live   = rst_n;
    a_adv  = !a_stall;  a_fl  = a_flush;  a_acc  = a_vld && !a_stall && !a_flush;  a_d = 128'(a_dat);
    b_adv  = !b_stall;  b_fl  = b_flush;  b_acc  = b_vld && !b_stall && !b_flush;  b_d = 128'(b_dat);
    cd_adv = !cd_stall; cd_fl = cd_flush; cd_acc = cd_vld && !cd_stall && !cd_flush;
    c_d = cd_dat;
    d_d = 128'(cd_dat[0]);
    e_adv  = !e_stall;  e_fl  = e_flush;  e_acc  = e_vld && !e_stall && !e_flush;  e_d = 128'(e_dat);
    bub = live && !e_stall && !e_ov;
    @(posedge clk);
    if (live) begin
      upd(0, 3, a_adv, a_fl, a_acc, a_d);
      upd(1, 2, b_adv, b_fl, b_acc, b_d);
      upd(2, 8, cd_adv, cd_fl, cd_acc, c_d);
      upd(3, 8, cd_adv, cd_fl, cd_acc, d_d);
      upd(4, 1, e_adv, e_fl, e_acc, e_d);
    end
    if (bub && exp_bub != 32'hFFFF_FFFF) exp_bub = exp_bub + 32'd1;
    #1;
    chk_inst(0, 3, "a", a_ov, 128'(a_od), a_occ);
    chk_inst(1, 2, "b", b_ov, 128'(b_od), b_occ);
    chk_inst(2, 8, "c", c_ov, c_od, c_occ);
    chk_inst(3, 8, "d", d_ov, 128'(d_od), d_occ);
    chk_inst(4, 1, "e", e_ov, 128'(e_od), e_occ);
`ifdef PIPE_STAGEREG_PERFCNT_EN
    chk("e.bubble_cnt", 128'(e_bub), 128'(exp_bub));
`endif
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".a"}, 128'({a_ov, a_od, a_occ}), 128'(0));
    chk({tag, ".b"}, 128'({b_ov, b_od, b_occ}), 128'(0));
    chk({tag, ".c"}, {c_od[126:0], c_ov} | 128'(c_occ), 128'(0));
    chk({tag, ".d"}, 128'({d_ov, d_od, d_occ}), 128'(0));
    chk({tag, ".e"}, 128'({e_ov, e_od, e_occ}), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] v [10];
    rst_n = 1'b0;
    a_vld = 0; a_stall = 0; a_flush = 0; a_dat = '0;
    b_vld = 0; b_stall = 0; b_flush = 0; b_dat = '0;
    cd_vld = 0; cd_stall = 0; cd_flush = 0; cd_dat = '0;
    e_vld = 0; e_stall = 0; e_flush = 0; e_dat = '0;
    exp_bub = '0;
    #3;
    chk_all_zero("reset");
    chk("c.out_data_msb", 128'(c_od[127]), 128'(0));
`ifdef PIPE_STAGEREG_PERFCNT_EN
    chk("reset.bubble_cnt", 128'(e_bub), 128'(0));
`endif
    tick();
    tick();
    rst_n = 1'b1;

    repeat (5) tick();
    e_stall = 1'b1;
    repeat (2) tick();
`ifdef PIPE_STAGEREG_PERFCNT_EN
    chk("perf.five_bubbles", 128'(e_bub), 128'(5));
`endif
    e_stall = 1'b0;

    a_stall = 1'b1; a_flush = 1'b1;
    #1;
    chk("a.in_ready_stalled", 128'(a_rdy), 128'(0));
    a_stall = 1'b0;
    #1;
    chk("a.in_ready_flush", 128'(a_rdy), 128'(1));
    a_flush = 1'b0;
    chk("bcde.in_ready", 128'({b_rdy, c_rdy, d_rdy, e_rdy}), 128'(4'hF));

    a_vld = 1'b1; a_dat = 32'hA1; tick();
    chk("a.lat_1", 128'(a_ov), 128'(0));
    a_dat = 32'hA2; tick();
    a_dat = 32'hA3; tick();
    chk("a.first_out", 128'(a_od), 128'(32'hA1));
    chk("a.full_occ", 128'(a_occ), 128'(3));
    a_dat = 32'hA4; tick();
    chk("a.second_out", 128'(a_od), 128'(32'hA2));
    a_dat = 32'hA5; tick();
    chk("a.third_out", 128'(a_od), 128'(32'hA3));

    a_stall = 1'b1; a_dat = 32'hEE;
    tick();
    chk("a.stall1", 128'({a_ov, a_od, a_occ}), 128'({1'b1, 32'hA3, 4'd3}));
    tick();
    chk("a.stall2", 128'({a_ov, a_od, a_occ}), 128'({1'b1, 32'hA3, 4'd3}));
    a_stall = 1'b0; a_vld = 1'b0;
    tick();
    chk("a.resume1", 128'(a_od), 128'(32'hA4));
    tick();
    chk("a.resume2", 128'(a_od), 128'(32'hA5));
    tick();
    chk("a.drained", 128'(a_ov), 128'(0));

    a_vld = 1'b1;
    a_dat = 32'hB1; tick();
    a_dat = 32'hB2; tick();
    a_dat = 32'hB3; tick();
    a_stall = 1'b1; a_flush = 1'b1; a_dat = 32'hFF;
    tick();
    chk("a.flush", 128'({a_ov, a_occ}), 128'(0));
    a_stall = 1'b0; a_flush = 1'b0; a_vld = 1'b0;
    repeat (3) begin
      tick();
      chk("a.no_ff", 128'(a_ov), 128'(0));
    end

    e_vld = 1'b1; e_dat = 16'h1234; tick();
    chk("e.single", 128'({e_ov, e_od}), 128'({1'b1, 16'h1234}));
    e_stall = 1'b1; e_dat = 16'h5678; tick();
    chk("e.hold", 128'({e_ov, e_od}), 128'({1'b1, 16'h1234}));
    e_stall = 1'b0; e_flush = 1'b1; tick();
    chk("e.flush", 128'(e_ov), 128'(0));
    e_flush = 1'b0; e_vld = 1'b0;

    v[0] = '1;
    v[1] = {1'b1, 126'd0, 1'b1};
    v[2] = {16{8'hA5}};
    for (int i = 3; i < 10; i++) v[i] = {$urandom, $urandom, $urandom, $urandom};
    cd_vld = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cd_dat = v[i];
      tick();
      if (i == 6) chk("c.lat_7", 128'(c_ov), 128'(0));
      if (i == 7) begin
        chk("c.lat_8", c_od, v[0]);
        chk("d.lat_8", 128'({d_ov, d_od}), 128'({1'b1, v[0][0]}));
      end
    end
    cd_vld = 1'b0;
    cd_flush = 1'b1; cd_vld = 1'b1; cd_dat = '0; tick();
    chk("c.flush", 128'({c_ov, c_occ}), 128'(0));
    cd_flush = 1'b0;
    cd_dat = v[1]; tick();
    cd_vld = 1'b0;
    repeat (9) tick();

    b_vld = 1'b1; b_dat = 8'h11; tick();
    b_dat = 8'h22; tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    sb.delete();
    exp_bub = '0;
    #1;
    rst_n = 1'b1;
    b_dat = 8'h55; tick();
    b_vld = 1'b0;
    chk("b.after_rst_1", 128'(b_ov), 128'(0));
    tick();
    chk("b.after_rst_2", 128'({b_ov, b_od}), 128'({1'b1, 8'h55}));
    repeat (2) tick();

`ifdef PIPE_STAGEREG_PERFCNT_EN
    force dut_e.r_bubble_cnt = 32'hFFFF_FFFE;
    #1;
    release dut_e.r_bubble_cnt;
    exp_bub = 32'hFFFF_FFFE;
    repeat (3) tick();
    chk("perf.saturate", 128'(e_bub), 128'(32'hFFFF_FFFF));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stagereg.md
PIPE_STAGEREG -- requirements
Module: pipe_stagereg

Interface
REQ-001 Parameter DATA_W, default 32, payload width in bits (1..128).
REQ-002 Parameter DEPTH, default 1, number of register stages between input and output (1..8).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port in_valid  input  1  payload at in_data is a real instruction (0 = bubble).
REQ-006 Port in_data  input  DATA_W  payload from upstream stage.
REQ-007 Port stall  input  1  hold all stages; no shift.
REQ-008 Port flush  input  1  kill all in-flight payloads.
REQ-009 Port in_ready  output  1  upstream may advance; equals ~stall.
REQ-010 Port out_valid  output  1  valid bit of last stage.
REQ-011 Port out_data  output  DATA_W  payload of last stage.
REQ-012 Port occupancy  output  4  count of stages holding valid=1 (0..DEPTH).

Function
REQ-013 Each stage k SHALL hold one valid bit and one DATA_W payload; stage 0 loads from in_valid/in_data, stage k loads from stage k-1.
REQ-014 Latency SHALL be exactly DEPTH cycles from an accepted input to out_valid/out_data, absent stall and flush.
REQ-015 out_valid/out_data SHALL be driven directly from last-stage registers; no combinational path from any input to them.
REQ-016 stall=1, flush=0: all valid bits and payloads SHALL hold; in_data/in_valid ignored that cycle.
REQ-017 flush=1: all valid bits SHALL clear at the next edge regardless of stall; payload registers may hold any value.
REQ-018 flush=1 and in_valid=1 same cycle: input SHALL be discarded (stage 0 valid = 0).
REQ-019 Payload of a stage whose valid is loaded 0 SHALL still capture incoming data (bubbles carry data, valid marks them dead).
REQ-020 occupancy SHALL equal popcount of stage valid bits, registered-consistent with them every cycle; flush drives it to 0 next cycle.
REQ-021 in_ready SHALL equal ~stall combinationally; flush does not affect in_ready.
REQ-022 DEPTH=1 SHALL behave as a single MEM/WB-style register with stall/flush.

Reset
REQ-023 reset=0 SHALL asynchronously clear every valid bit, every payload register to 0, occupancy to 0, and the perf counter (if present) to 0.
REQ-024 Reset assertion mid-stream SHALL discard all in-flight payloads; first accepted input after release appears at out_valid after DEPTH edges.
REQ-025 Outputs SHALL be out_valid=0, out_data=0, occupancy=0 while reset=0.

Configuration
REQ-026 Macro PIPE_STAGEREG_PERFCNT_EN, when defined, SHALL add output bubble_cnt (32 bits): increments on every edge where reset=1, stall=0 and out_valid=0; saturates at 0xFFFFFFFF; cleared only by reset.
REQ-027 Macro undefined: no bubble_cnt port, no counter logic; all other behaviour identical.

Verification
REQ-028 DEPTH=3, inputs valid=1 data 0xA1,0xA2,0xA3 on consecutive cycles -> out_data 0xA1,0xA2,0xA3 with out_valid=1 on cycles 3,4,5; occupancy reaches 3.
REQ-029 DEPTH=3, pipe full, stall=1 for 2 cycles -> out_data/out_valid/occupancy unchanged 2 cycles; stream resumes in order after stall=0.
REQ-030 DEPTH=3, pipe full, stall=1 and flush=1 same cycle with in_valid=1 data 0xFF -> next cycle occupancy=0, out_valid=0; 0xFF never appears valid.
REQ-031 DEPTH=2, reset pulsed low mid-stream (async, between edges) -> out_valid=0, out_data=0, occupancy=0 immediately; input 0x55 after release valid at out after 2 edges.
REQ-032 PIPE_STAGEREG_PERFCNT_EN defined, DEPTH=1, 5 idle cycles then 2 stalled idle cycles -> bubble_cnt=5; forced to 0xFFFFFFFE plus 3 idle cycles -> 0xFFFFFFFF.
REQ-033 DATA_W=1 and DATA_W=128, DEPTH=8 -> latency 8 cycles, full-width payload preserved bit-exact.
